// File: rtl/anomaly_alarm_filter.sv
// Sliding-window anomaly density filter with hysteretic, hold-off debounced alarm,
// sticky software-acknowledged alarm flag and a saturating anomaly event total.
module anomaly_alarm_filter #(
    parameter int WINDOW    = 16,
    parameter int HI_THRESH = 4,
    parameter int LO_THRESH = 1,
    parameter int HOLDOFF   = 8,
    parameter int CNT_W     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         decision_valid,
    input  logic                         anomaly_in,
    input  logic                         alarm_ack,
    output logic [$clog2(WINDOW+1)-1:0]  window_count,
    output logic                         alarm,
    output logic                         alarm_rise,
    output logic                         alarm_latched,
    output logic [CNT_W-1:0]             event_total
);
    localparam int CW = $clog2(WINDOW + 1);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam logic [CW-1:0] HI_LIM    = CW'(HI_THRESH);
    localparam logic [CW-1:0] LO_LIM    = CW'(LO_THRESH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

    typedef enum logic [1:0] {IDLE, HOLD, ACTIVE} state_t;

    state_t             state_q, state_d;
    logic [WINDOW-1:0]  history_q, history_d;
    logic [CW-1:0]      count_q, count_d, new_count;
    logic [HW-1:0]      hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]   total_q, total_d;
    logic               rise_q, rise_d;
    logic               latched_q, latched_d;

    // The decision leaving the window is the oldest history bit.
    assign new_count = count_q + {{(CW-1){1'b0}}, anomaly_in}
                               - {{(CW-1){1'b0}}, history_q[WINDOW-1]};

    always_comb begin
        state_d    = state_q;
        history_d  = history_q;
        count_d    = count_q;
        hold_cnt_d = hold_cnt_q;
        total_d    = total_q;
        rise_d     = 1'b0;

        if (decision_valid) begin
            history_d = {history_q[WINDOW-2:0], anomaly_in};
            count_d   = new_count;
            if (anomaly_in && (total_q != {CNT_W{1'b1}})) begin
                total_d = total_q + 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (new_count >= HI_LIM) begin
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                        rise_d     = 1'b1;
                    end
                end
                HOLD: begin
                    // Falling density is ignored until the hold-off period expires.
                    hold_cnt_d = hold_cnt_q + 1'b1;
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d = (new_count <= LO_LIM) ? IDLE : ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (new_count <= LO_LIM) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A new rise takes priority over a simultaneous acknowledge.
        if (rise_d) begin
            latched_d = 1'b1;
        end else if (alarm_ack) begin
            latched_d = 1'b0;
        end else begin
            latched_d = latched_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            history_q  <= '0;
            count_q    <= '0;
            hold_cnt_q <= '0;
            total_q    <= '0;
            rise_q     <= 1'b0;
            latched_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            history_q  <= history_d;
            count_q    <= count_d;
            hold_cnt_q <= hold_cnt_d;
            total_q    <= total_d;
            rise_q     <= rise_d;
            latched_q  <= latched_d;
        end
    end

    assign window_count  = count_q;
    assign alarm         = (state_q != IDLE);
    assign alarm_rise    = rise_q;
    assign alarm_latched = latched_q;
    assign event_total   = total_q;
endmodule

// File: tb/tb_anomaly_alarm_filter.sv
// Directed plus randomized bench for anomaly_alarm_filter; two parameterizations
// share the same stimulus and are compared against a queue-based reference model.
module tb_anomaly_alarm_filter;
    logic clk = 1'b0;
    logic reset, decision_valid, anomaly_in, alarm_ack;

    logic [4:0] wc_a;
    logic       alarm_a, rise_a, latch_a;
    logic [7:0] tot_a;
    logic [2:0] wc_b;
    logic       alarm_b, rise_b, latch_b;
    logic [3:0] tot_b;

    int tests = 0;
    int fails = 0;

    // Reference parameters per instance: a = defaults, b = small window / narrow total.
    int P_W[2]   = '{16, 4};
    int P_HI[2]  = '{4, 3};
    int P_LO[2]  = '{1, 1};
    int P_HO[2]  = '{8, 8};
    int P_MAX[2] = '{255, 15};

    bit log_q[$];
    int m_count[2], m_total[2], m_since[2];
    bit m_alarm[2], m_rise[2], m_latch[2];

    always #5 clk = ~clk;

    anomaly_alarm_filter u_a (
        .clk(clk), .reset(reset), .decision_valid(decision_valid),
        .anomaly_in(anomaly_in), .alarm_ack(alarm_ack),
        .window_count(wc_a), .alarm(alarm_a), .alarm_rise(rise_a),
        .alarm_latched(latch_a), .event_total(tot_a)
    );

    anomaly_alarm_filter #(
        .WINDOW(4), .HI_THRESH(3), .LO_THRESH(1), .HOLDOFF(8), .CNT_W(4)
    ) u_b (
        .clk(clk), .reset(reset), .decision_valid(decision_valid),
        .anomaly_in(anomaly_in), .alarm_ack(alarm_ack),
        .window_count(wc_b), .alarm(alarm_b), .alarm_rise(rise_b),
        .alarm_latched(latch_b), .event_total(tot_b)
    );

    task automatic chk(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    // Window count = number of anomalies among the last W accepted decisions since reset.
    function automatic int last_w_sum(input int w);
        int s = 0;
        for (int j = 0; j < w && j < log_q.size(); j++) begin
            s += int'(log_q[log_q.size() - 1 - j]);
        end
        return s;
    endfunction

    task automatic model_update(input bit v, input bit a, input bit k, input bit r);
        if (r) begin
            log_q.delete();
            for (int i = 0; i < 2; i++) begin
                m_count[i] = 0; m_total[i] = 0; m_since[i] = 0;
                m_alarm[i] = 0; m_rise[i] = 0; m_latch[i] = 0;
            end
            return;
        end
        if (v) log_q.push_back(a);
        for (int i = 0; i < 2; i++) begin
            m_rise[i] = 1'b0;
            if (v) begin
                m_count[i] = last_w_sum(P_W[i]);
                if (a && m_total[i] < P_MAX[i]) m_total[i]++;
                if (!m_alarm[i]) begin
                    if (m_count[i] >= P_HI[i]) begin
                        m_alarm[i] = 1'b1;
                        m_rise[i]  = 1'b1;
                        m_since[i] = 0;
                    end
                end else begin
                    m_since[i]++;
                    if (m_since[i] >= P_HO[i] && m_count[i] <= P_LO[i]) m_alarm[i] = 1'b0;
                end
            end
            if (m_rise[i]) m_latch[i] = 1'b1;
            else if (k)    m_latch[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("a.window_count", int'(wc_a),  m_count[0]);
        chk("a.alarm",        int'(alarm_a), int'(m_alarm[0]));
        chk("a.alarm_rise",   int'(rise_a),  int'(m_rise[0]));
        chk("a.alarm_latched",int'(latch_a), int'(m_latch[0]));
        chk("a.event_total",  int'(tot_a),   m_total[0]);
        chk("b.window_count", int'(wc_b),  m_count[1]);
        chk("b.alarm",        int'(alarm_b), int'(m_alarm[1]));
        chk("b.alarm_rise",   int'(rise_b),  int'(m_rise[1]));
        chk("b.alarm_latched",int'(latch_b), int'(m_latch[1]));
        chk("b.event_total",  int'(tot_b),   m_total[1]);
    endtask

    task automatic step(input bit v, input bit a, input bit k, input bit r);
        decision_valid = v; anomaly_in = a; alarm_ack = k; reset = r;
        @(posedge clk);
        model_update(v, a, k, r);
        #1;
        check_all();
    endtask

    initial begin
        int p;
        reset = 1'b1; decision_valid = 1'b1; anomaly_in = 1'b1; alarm_ack = 1'b0;

        // Reset with strobes active: everything must stay cleared.
        step(1, 1, 0, 1);
        step(1, 1, 0, 1);
        chk("rst.total", int'(tot_a), 0);
        repeat (3) step(0, 1, 0, 0);
        chk("idle.count", int'(wc_a), 0);

        // Four anomalies: counts 1..4, rise after the 4th; ack on that edge loses to the set.
        for (int n = 1; n <= 4; n++) begin
            step(1, 1, (n == 4), 0);
            chk("ramp.count", int'(wc_a), n);
        end
        chk("ramp.rise",  int'(rise_a),  1);
        chk("ramp.latch", int'(latch_a), 1);

        // Sixteen normals: hold-off, then hysteresis until count reaches LO.
        for (int n = 1; n <= 16; n++) begin
            step(1, 0, (n == 2), 0);
            chk("decay.count", int'(wc_a), (n <= 12) ? 4 : 16 - n);
            chk("decay.alarm", int'(alarm_a), (n < 15) ? 1 : 0);
            if (n == 1) chk("decay.single_rise", int'(rise_a), 0);
            if (n == 2) chk("decay.ack_clear", int'(latch_a), 0);
        end

        // Saturation: narrow instance total holds at 15.
        repeat (20) step(1, 1, 0, 0);
        chk("sat.b_total", int'(tot_b), 15);
        chk("sat.a_count", int'(wc_a), 16);
        step(1, 1, 0, 1);

        // Randomized traffic with density phases so alarms rise and fall repeatedly.
        p = 50;
        for (int n = 0; n < 1500; n++) begin
            if (n % 60 == 0) p = $urandom_range(0, 100);
            step(($urandom_range(0, 99) < 75),
                 ($urandom_range(0, 99) < p),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/anomaly_alarm_filter.md
Name: anomaly_alarm_filter

Overview:
- Downstream of the isolation-tree decision stage; consumes one anomaly decision per processed sample.
- Keeps a sliding window of the last WINDOW decisions and raises a debounced, hysteretic alarm from the anomaly density in that window.
- Also keeps a sticky alarm flag cleared by software ack, and a saturating total of anomaly decisions.
- Filters isolated false positives from the per-sample tree output before they reach the system alarm logic.

Parameters:
- WINDOW, 16, number of most recent decisions in the sliding window (legal 2..64).
- HI_THRESH, 4, alarm sets when window count >= HI_THRESH (LO_THRESH < HI_THRESH <= WINDOW).
- LO_THRESH, 1, alarm clears when window count <= LO_THRESH.
- HOLDOFF, 8, minimum number of accepted decisions the alarm stays high after rising (>= 1).
- CNT_W, 8, width of event_total.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- decision_valid  in  1  one-cycle strobe: a new tree decision is available (driven from the tree stage's data_processed).
- anomaly_in  in  1  decision value; sampled only when decision_valid=1.
- alarm_ack  in  1  clears alarm_latched.
- window_count  out  $clog2(WINDOW+1)  number of anomalies among the last WINDOW decisions.
- alarm  out  1  filtered alarm level.
- alarm_rise  out  1  one-cycle pulse on the alarm 0->1 transition.
- alarm_latched  out  1  sticky alarm flag.
- event_total  out  CNT_W  saturating count of accepted anomaly decisions.

Behaviour:
- Reset (sync, active-high): history register, window_count, event_total, holdoff counter = 0; FSM = IDLE; alarm, alarm_rise, alarm_latched = 0. Inputs are ignored in any cycle with reset=1. Reset mid-alarm clears everything on that edge.
- Accepted decision = decision_valid=1 in a non-reset cycle. Non-accepted cycles change only alarm_rise (forced 0) and alarm_latched (ack).
- History: WINDOW-bit shift register. On accept, shift in anomaly_in; the oldest bit drops out.
- new_count = window_count + anomaly_in - oldest_bit. Registered on the accept edge, visible the cycle after decision_valid. Never exceeds WINDOW; no wrap.
- event_total increments on an accepted anomaly_in=1 and holds at 2^CNT_W-1 (saturates).
- All FSM decisions use new_count, so alarm changes on the same edge as window_count (latency 1 cycle from decision_valid).
- FSM states:
  - IDLE: alarm=0. On accept with new_count >= HI_THRESH, go to HOLD, clear the holdoff counter, and pulse alarm_rise for 1 cycle.
  - HOLD: alarm=1. Each accept increments the holdoff counter; a falling count is ignored. On the HOLDOFF-th accept in HOLD, go to IDLE if new_count <= LO_THRESH, otherwise go to ACTIVE.
  - ACTIVE: alarm=1. On accept with new_count <= LO_THRESH, go to IDLE. Counts between LO and HI keep the alarm high (hysteresis).
- alarm_latched: set on the alarm_rise edge; cleared by alarm_ack=1. If set and ack occur in the same cycle, set wins. Ack while alarm=1 with no rise clears the flag; alarm itself is unaffected.
- alarm_rise never asserts for two consecutive cycles. It cannot re-fire until the FSM has passed through IDLE.

Test Plan:
- Reset: assert reset 2 cycles with decision_valid=1, anomaly_in=1 -> all outputs 0 and event_total=0 after release. decision_valid=0 with anomaly_in=1 -> window_count stays 0.
- Defaults, 4 consecutive anomaly decisions -> window_count 1,2,3,4. alarm=1 and alarm_rise=1 (single cycle) in the cycle after the 4th strobe; alarm_latched=1.
- Defaults, 4 anomalies then 16 normals -> window_count stays 4 through the 12th normal, then 3,2,1. alarm drops to 0 after the 15th normal (count 1, ACTIVE).
- WINDOW=4, HI=3, LO=1, HOLDOFF=8: 3 anomalies then normals -> window_count 3,2,1,0,0... with alarm held high. alarm=0 after the 8th decision following the rise.
- Sticky: alarm_ack=1 in the same cycle as the rising edge -> alarm_latched=1. alarm_ack=1 two cycles later -> alarm_latched=0 while alarm stays 1.
- CNT_W=4, 20 anomaly decisions -> event_total reaches 15 and holds 15; window_count=16 (WINDOW=16).
